// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM unified RAM port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam int DEFAULT_WAIT_STATES = 1;
  localparam int CNT_W               = 4;
  localparam int MAX_WAIT_STATES     = 15;

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable 4-bit down-counter that times the RAM wait states of one access.
module arb_wait_counter
  import mem_port_arbiter_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Load takes priority; decrement saturates at zero so an idle dec is harmless.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and MEM stage accesses onto one single-ported RAM and stalls the pipeline.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES,
  parameter int AW          = 8,
  parameter int DW          = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_ready,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          stall
);

  // The wait counter is only 4 bits wide, so larger settings cannot be honoured.
  if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait_states
    $error("mem_port_arbiter: WAIT_STATES must be within 0..15");
  end

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

  state_t          state;
  owner_t          owner;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic            lat_we;
  logic [CNT_W-1:0] cnt;
  logic            cnt_zero;
  logic            mem_req;
  logic            cnt_load;
  logic            cnt_dec;

  assign mem_req  = mem_read | mem_write;
  assign cnt_load = (state == ST_IDLE) && (mem_req || if_req);
  assign cnt_dec  = (state == ST_ACCESS);

  arb_wait_counter u_wait_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (WAIT_LOAD),
    .dec        (cnt_dec),
    .count      (cnt),
    .zero       (cnt_zero)
  );

  // Grant/access/response sequencer; MEM wins over IF, ready pulses are registered into RESP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_req) begin
            owner     <= OWN_MEM;
            lat_addr  <= mem_addr;
            lat_wdata <= mem_wdata;
            lat_we    <= mem_write;
            state     <= ST_ACCESS;
          end else if (if_req) begin
            owner     <= OWN_IF;
            lat_addr  <= if_addr;
            lat_wdata <= mem_wdata;
            lat_we    <= 1'b0;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_zero) begin
            if (owner == OWN_IF) begin
              if_rdata <= ram_rdata;
              if_ready <= 1'b1;
            end else begin
              if (!lat_we) begin
                mem_rdata <= ram_rdata;
              end
              mem_ready <= 1'b1;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ram_en    = (state == ST_ACCESS);
  assign ram_we    = ram_en & lat_we;
  assign ram_addr  = lat_addr;
  assign ram_wdata = lat_wdata;

  // A requester is frozen until its completion pulse; reset forces the stall low.
  assign stall = ~reset & ((if_req & ~if_ready) | (mem_req & ~mem_ready));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with a behavioural RAM model.
module tb_mem_port_arbiter;

  logic       clock;
  logic       reset;

  // DUT with one wait state
  logic       if_req;
  logic [7:0] if_addr;
  logic [7:0] if_rdata;
  logic       if_ready;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       stall;

  // DUT with zero wait states (fetch-only traffic)
  logic       if_req0;
  logic [7:0] if_addr0;
  logic [7:0] if_rdata0;
  logic       if_ready0;
  logic       mem_read0;
  logic       mem_write0;
  logic [7:0] mem_addr0;
  logic [7:0] mem_wdata0;
  logic [7:0] mem_rdata0;
  logic       mem_ready0;
  logic       ram_en0;
  logic       ram_we0;
  logic [7:0] ram_addr0;
  logic [7:0] ram_wdata0;
  logic [7:0] ram_rdata0;
  logic       stall0;

  int num_checks;
  int num_fails;

  logic [7:0] ram_mem [256];
  logic       ram_written [256];

  typedef struct {
    logic       if_req;
    logic [7:0] if_addr;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       exp_en;
    logic       exp_we;
    logic       exp_if_ready;
    logic       exp_mem_ready;
    logic       exp_stall;
    logic [7:0] exp_addr;
    logic [7:0] exp_if_rdata;
    logic [7:0] exp_mem_rdata;
  } vec_t;

  vec_t vecs[$];

  mem_port_arbiter #(.WAIT_STATES(1), .AW(8), .DW(8)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .stall     (stall)
  );

  mem_port_arbiter #(.WAIT_STATES(0), .AW(8), .DW(8)) u_dut0 (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req0),
    .if_addr   (if_addr0),
    .if_rdata  (if_rdata0),
    .if_ready  (if_ready0),
    .mem_read  (mem_read0),
    .mem_write (mem_write0),
    .mem_addr  (mem_addr0),
    .mem_wdata (mem_wdata0),
    .mem_rdata (mem_rdata0),
    .mem_ready (mem_ready0),
    .ram_en    (ram_en0),
    .ram_we    (ram_we0),
    .ram_addr  (ram_addr0),
    .ram_wdata (ram_wdata0),
    .ram_rdata (ram_rdata0),
    .stall     (stall0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Power-on contents of the shared RAM
  function automatic logic [7:0] ram_init(input logic [7:0] a);
    case (a)
      8'h05:   return 8'hA3;
      8'h06:   return 8'h3C;
      8'h10:   return 8'h7F;
      default: return 8'h00;
    endcase
  endfunction

  // Contents of the read-only RAM behind the zero-wait DUT
  function automatic logic [7:0] rom0(input logic [7:0] a);
    return a ^ 8'hC5;
  endfunction

  // Synchronous-write, combinational-read RAM model
  always @(posedge clock) begin
    if (ram_en && ram_we) begin
      ram_mem[ram_addr]     <= ram_wdata;
      ram_written[ram_addr] <= 1'b1;
    end
  end

  assign ram_rdata  = (ram_written[ram_addr] === 1'b1) ? ram_mem[ram_addr] : ram_init(ram_addr);
  assign ram_rdata0 = rom0(ram_addr0);

  function automatic vec_t mk(input logic ir, input logic [7:0] ia, input logic rd, input logic wr,
                              input logic [7:0] ma, input logic [7:0] wd, input logic en, input logic we,
                              input logic ifr, input logic mrdy, input logic st, input logic [7:0] ad,
                              input logic [7:0] ifd, input logic [7:0] md);
    vec_t v;
    v.if_req = ir;  v.if_addr = ia;  v.mem_read = rd;  v.mem_write = wr;
    v.mem_addr = ma;  v.mem_wdata = wd;
    v.exp_en = en;  v.exp_we = we;  v.exp_if_ready = ifr;  v.exp_mem_ready = mrdy;
    v.exp_stall = st;  v.exp_addr = ad;  v.exp_if_rdata = ifd;  v.exp_mem_rdata = md;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    if_req    = v.if_req;
    if_addr   = v.if_addr;
    mem_read  = v.mem_read;
    mem_write = v.mem_write;
    mem_addr  = v.mem_addr;
    mem_wdata = v.mem_wdata;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  initial begin
    int got;
    num_checks = 0;
    num_fails  = 0;
    for (int a = 0; a < 256; a++) ram_written[a] = 1'b0;

    // Reset with requests already present: everything, including stall, must read 0
    reset = 1'b1;
    if_req = 1'b1;  if_addr = 8'h05;
    mem_read = 1'b1;  mem_write = 1'b0;  mem_addr = 8'h10;  mem_wdata = 8'h00;
    if_req0 = 1'b0;  if_addr0 = 8'h00;
    mem_read0 = 1'b0;  mem_write0 = 1'b0;  mem_addr0 = 8'h00;  mem_wdata0 = 8'h00;
    #7;
    checkOutput("reset ram_en", {7'd0, ram_en}, 8'h00);
    checkOutput("reset ram_we", {7'd0, ram_we}, 8'h00);
    checkOutput("reset stall", {7'd0, stall}, 8'h00);
    checkOutput("reset if_ready", {7'd0, if_ready}, 8'h00);
    checkOutput("reset mem_ready", {7'd0, mem_ready}, 8'h00);
    checkOutput("reset if_rdata", if_rdata, 8'h00);
    checkOutput("reset mem_rdata", mem_rdata, 8'h00);
    checkOutput("reset ram_addr", ram_addr, 8'h00);
    @(negedge clock);
    if_req = 1'b0;  mem_read = 1'b0;
    reset = 1'b0;

    // Fetch with one wait state
    vecs.push_back(mk(1, 8'h05, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(1, 8'h05, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h05, 8'h00, 8'h00));
    vecs.push_back(mk(1, 8'h05, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h05, 8'h00, 8'h00));
    vecs.push_back(mk(1, 8'h05, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 8'h05, 8'hA3, 8'h00));
    vecs.push_back(mk(0, 8'h05, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h05, 8'hA3, 8'h00));
    // Simultaneous fetch and load: load served first, fetch WAIT_STATES+3 cycles later
    vecs.push_back(mk(1, 8'h05, 1, 0, 8'h10, 8'h00, 0, 0, 0, 0, 1, 8'h05, 8'hA3, 8'h00));
    vecs.push_back(mk(1, 8'h05, 1, 0, 8'h10, 8'h00, 1, 0, 0, 0, 1, 8'h10, 8'hA3, 8'h00));
    vecs.push_back(mk(1, 8'h05, 1, 0, 8'h10, 8'h00, 1, 0, 0, 0, 1, 8'h10, 8'hA3, 8'h00));
    vecs.push_back(mk(1, 8'h05, 1, 0, 8'h10, 8'h00, 0, 0, 0, 1, 1, 8'h10, 8'hA3, 8'h7F));
    vecs.push_back(mk(1, 8'h05, 0, 0, 8'h10, 8'h00, 0, 0, 0, 0, 1, 8'h10, 8'hA3, 8'h7F));
    vecs.push_back(mk(1, 8'h05, 0, 0, 8'h10, 8'h00, 1, 0, 0, 0, 1, 8'h05, 8'hA3, 8'h7F));
    vecs.push_back(mk(1, 8'h05, 0, 0, 8'h10, 8'h00, 1, 0, 0, 0, 1, 8'h05, 8'hA3, 8'h7F));
    vecs.push_back(mk(1, 8'h05, 0, 0, 8'h10, 8'h00, 0, 0, 1, 0, 0, 8'h05, 8'hA3, 8'h7F));
    // Store: ram_we through all of ACCESS, mem_rdata untouched
    vecs.push_back(mk(0, 8'h00, 0, 1, 8'h20, 8'h5A, 0, 0, 0, 0, 1, 8'h05, 8'hA3, 8'h7F));
    vecs.push_back(mk(0, 8'h00, 0, 1, 8'h20, 8'h5A, 1, 1, 0, 0, 1, 8'h20, 8'hA3, 8'h7F));
    vecs.push_back(mk(0, 8'h00, 0, 1, 8'h20, 8'h5A, 1, 1, 0, 0, 1, 8'h20, 8'hA3, 8'h7F));
    vecs.push_back(mk(0, 8'h00, 0, 1, 8'h20, 8'h5A, 0, 0, 0, 1, 0, 8'h20, 8'hA3, 8'h7F));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h20, 8'hA3, 8'h7F));
    // Read and write together behave as a write
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h30, 8'hC3, 0, 0, 0, 0, 1, 8'h20, 8'hA3, 8'h7F));
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h30, 8'hC3, 1, 1, 0, 0, 1, 8'h30, 8'hA3, 8'h7F));
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h30, 8'hC3, 1, 1, 0, 0, 1, 8'h30, 8'hA3, 8'h7F));
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h30, 8'hC3, 0, 0, 0, 1, 0, 8'h30, 8'hA3, 8'h7F));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h30, 8'hA3, 8'h7F));
    // Fetch request dropped mid-access still completes
    vecs.push_back(mk(1, 8'h06, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h30, 8'hA3, 8'h7F));
    vecs.push_back(mk(1, 8'h06, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 1, 8'h06, 8'hA3, 8'h7F));
    vecs.push_back(mk(0, 8'h06, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h06, 8'hA3, 8'h7F));
    vecs.push_back(mk(0, 8'h06, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 8'h06, 8'h3C, 8'h7F));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h06, 8'h3C, 8'h7F));

    foreach (vecs[i]) begin
      @(negedge clock);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("row%0d ram_en", i), {7'd0, ram_en}, {7'd0, vecs[i].exp_en});
      checkOutput($sformatf("row%0d ram_we", i), {7'd0, ram_we}, {7'd0, vecs[i].exp_we});
      checkOutput($sformatf("row%0d if_ready", i), {7'd0, if_ready}, {7'd0, vecs[i].exp_if_ready});
      checkOutput($sformatf("row%0d mem_ready", i), {7'd0, mem_ready}, {7'd0, vecs[i].exp_mem_ready});
      checkOutput($sformatf("row%0d stall", i), {7'd0, stall}, {7'd0, vecs[i].exp_stall});
      checkOutput($sformatf("row%0d ram_addr", i), ram_addr, vecs[i].exp_addr);
      checkOutput($sformatf("row%0d if_rdata", i), if_rdata, vecs[i].exp_if_rdata);
      checkOutput($sformatf("row%0d mem_rdata", i), mem_rdata, vecs[i].exp_mem_rdata);
    end
    checkOutput("store RAM[0x20]", ram_mem[8'h20], 8'h5A);
    checkOutput("rd+wr RAM[0x30]", ram_mem[8'h30], 8'hC3);

    // Zero wait states: four back-to-back fetches complete every third cycle
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if ((c % 3) == 0) begin
        if_req0  = 1'b1;
        if_addr0 = 8'(c / 3);
      end
      #1;
      checkOutput($sformatf("ws0 c%0d ram_en", c), {7'd0, ram_en0}, {7'd0, ((c % 3) == 1)});
      checkOutput($sformatf("ws0 c%0d if_ready", c), {7'd0, if_ready0}, {7'd0, ((c % 3) == 2)});
      checkOutput($sformatf("ws0 c%0d stall", c), {7'd0, stall0}, {7'd0, ((c % 3) != 2)});
      checkOutput($sformatf("ws0 c%0d ram_we", c), {7'd0, ram_we0}, 8'h00);
      checkOutput($sformatf("ws0 c%0d mem_ready", c), {7'd0, mem_ready0}, 8'h00);
      if ((c % 3) == 2) begin
        checkOutput($sformatf("ws0 c%0d if_rdata", c), if_rdata0, rom0(8'(c / 3)));
      end
    end
    @(negedge clock);
    if_req0 = 1'b0;

    // Reset in the middle of a store: port released at once, write abandoned
    @(negedge clock);
    mem_write = 1'b1;  mem_addr = 8'h40;  mem_wdata = 8'h11;
    @(negedge clock);
    #1;
    checkOutput("pre-reset ram_en", {7'd0, ram_en}, 8'h01);
    checkOutput("pre-reset ram_we", {7'd0, ram_we}, 8'h01);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid reset ram_en", {7'd0, ram_en}, 8'h00);
    checkOutput("mid reset ram_we", {7'd0, ram_we}, 8'h00);
    checkOutput("mid reset stall", {7'd0, stall}, 8'h00);
    checkOutput("mid reset mem_ready", {7'd0, mem_ready}, 8'h00);
    checkOutput("mid reset if_rdata", if_rdata, 8'h00);
    checkOutput("mid reset mem_rdata", mem_rdata, 8'h00);
    checkOutput("mid reset ram_addr", ram_addr, 8'h00);
    checkOutput("mid reset ram_wdata", ram_wdata, 8'h00);
    @(negedge clock);
    mem_write = 1'b0;
    reset = 1'b0;
    checkOutput("abandoned store RAM[0x40]", {7'd0, ram_written[8'h40]}, 8'h00);

    // Fresh fetch after reset completes with normal latency
    @(negedge clock);
    if_req = 1'b1;  if_addr = 8'h05;
    got = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      #1;
      if (if_ready) begin
        got = c;
        break;
      end
    end
    checkOutput("post-reset fetch latency", 8'(got), 8'd3);
    checkOutput("post-reset if_rdata", if_rdata, 8'hA3);
    @(negedge clock);
    if_req = 1'b0;
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
